// File: rtl/am_inserter_pkg.sv
// am_inserter_pkg: shared widths, Clause 82 lane marker table, FSM states and BIP8 helper
package am_inserter_pkg;
    localparam int N_LANES          = 20;
    localparam int NB_DATA          = 66;
    localparam int NB_DATA_BUS      = N_LANES * NB_DATA;
    localparam int NB_AM_PERIOD     = 14;
    localparam int NB_ERROR_COUNTER = 16;
    localparam logic [1:0] SH_CTRL  = 2'b10;
    typedef enum logic [1:0] {IDLE, WAIT_GAP, RUN} state_t;
    // {M0,M1,M2} per lane, M0 is the first payload byte on the wire
    localparam logic [23:0] AM_TABLE [N_LANES] = '{
        24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
        24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
        24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
        24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5
    };
    function automatic logic [7:0] bip_of(input logic [NB_DATA-1:0] b);
        logic [7:0] p;
        p = '0;
        for (int k = 0; k < 64; k++) p[k[2:0]] ^= b[k];
        p[3] ^= b[64];
        p[4] ^= b[65];
        return p;
    endfunction
endpackage

// File: rtl/am_bip_calc.sv
// am_bip_calc: per-lane BIP8 accumulator and alignment-marker assembly
module am_bip_calc
    import am_inserter_pkg::*;
#(
    parameter int LANE = 0
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic               i_enb,
    input  logic               i_insert,
    input  logic [NB_DATA-1:0] i_data,
    output logic [NB_DATA-1:0] o_block
);
    logic [7:0] bip;
    logic [23:0] m;
    logic [NB_DATA-1:0] marker;
    assign m = AM_TABLE[LANE];
    assign marker = {SH_CTRL, m, bip, ~m, ~bip};
    assign o_block = i_insert ? marker : i_data;
    // after a marker the parity restarts from the marker's own contribution
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) bip <= '0;
        else if (!i_enb) bip <= '0;
        else if (i_valid) bip <= i_insert ? bip_of(marker) : bip ^ bip_of(i_data);
    end
endmodule

// File: rtl/am_inserter.sv
// am_inserter: replaces tagged clock-compensation words with per-lane alignment markers
module am_inserter
    import am_inserter_pkg::*;
(
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_valid,
    input  logic [NB_DATA_BUS-1:0]      i_data,
    input  logic                        i_tag,
    input  logic                        i_rf_enb,
    input  logic [NB_AM_PERIOD-1:0]     i_rf_am_period,
    output logic [NB_DATA_BUS-1:0]      o_data,
    output logic                        o_valid,
    output logic                        o_am_insert,
    output logic [NB_ERROR_COUNTER-1:0] o_rf_gap_error_counter,
    output logic                        o_rf_am_locked
);
    state_t state, next_state;
    logic [NB_AM_PERIOD-1:0] count, next_count;
    logic insert, gap_err;
    logic [NB_DATA_BUS-1:0] lane_out;
    always_comb begin
        next_state = state;
        next_count = count;
        insert     = 1'b0;
        gap_err    = 1'b0;
        if (!i_rf_enb) begin
            next_state = IDLE;
            next_count = '0;
        end else if (i_valid) begin
            case (state)
                IDLE: next_state = WAIT_GAP;
                WAIT_GAP: if (i_tag) begin
                    insert     = 1'b1;
                    next_count = '0;
                    next_state = RUN;
                end
                default: if (i_tag) begin
                    insert     = 1'b1;
                    next_count = '0;
                    gap_err    = count != i_rf_am_period;
                end else if (count >= i_rf_am_period) begin
                    gap_err    = 1'b1;
                    next_count = '0;
                    next_state = WAIT_GAP;
                end else next_count = count + 1'b1;
            endcase
        end
    end
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state                  <= IDLE;
            count                  <= '0;
            o_data                 <= '0;
            o_valid                <= 1'b0;
            o_am_insert            <= 1'b0;
            o_rf_gap_error_counter <= '0;
        end else begin
            state       <= next_state;
            count       <= next_count;
            o_valid     <= i_valid;
            o_am_insert <= insert;
            if (i_valid) o_data <= lane_out;
            if (gap_err && !(&o_rf_gap_error_counter))
                o_rf_gap_error_counter <= o_rf_gap_error_counter + 1'b1;
        end
    end
    assign o_rf_am_locked = state == RUN;
    for (genvar n = 0; n < N_LANES; n++) begin : g_lane
        am_bip_calc #(.LANE(n)) u_bip (
            .i_clock (i_clock),
            .i_reset (i_reset),
            .i_valid (i_valid),
            .i_enb   (i_rf_enb),
            .i_insert(insert),
            .i_data  (i_data[n*NB_DATA +: NB_DATA]),
            .o_block (lane_out[n*NB_DATA +: NB_DATA])
        );
    end
endmodule

// File: tb/tb_am_inserter.sv
// tb_am_inserter: directed scenario tests with hand-computed markers and BIP values
module tb_am_inserter;
    import am_inserter_pkg::*;
    logic i_clock = 1'b0;
    logic i_reset = 1'b0;
    logic i_valid = 1'b0;
    logic i_tag = 1'b0;
    logic i_rf_enb = 1'b0;
    logic [NB_DATA_BUS-1:0] i_data = '0;
    logic [NB_AM_PERIOD-1:0] i_rf_am_period = 14'd4;
    logic [NB_DATA_BUS-1:0] o_data;
    logic o_valid, o_am_insert, o_rf_am_locked;
    logic [NB_ERROR_COUNTER-1:0] o_rf_gap_error_counter;
    int tot = 0;
    int bad = 0;
    localparam logic [65:0] D01 = {2'b01, 64'h0};
    localparam logic [65:0] D2  = {2'b10, 64'h1};
    localparam logic [65:0] TG  = {2'b01, 64'hDEAD_BEEF_0123_4567};
    localparam logic [23:0] M_L0  = 24'hC16821;
    localparam logic [23:0] M_L19 = 24'hC0F0E5;

    am_inserter dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_data(i_data),
        .i_tag(i_tag), .i_rf_enb(i_rf_enb), .i_rf_am_period(i_rf_am_period),
        .o_data(o_data), .o_valid(o_valid), .o_am_insert(o_am_insert),
        .o_rf_gap_error_counter(o_rf_gap_error_counter), .o_rf_am_locked(o_rf_am_locked)
    );

    always #5 i_clock = ~i_clock;

    function automatic logic [NB_DATA_BUS-1:0] rep(input logic [65:0] b);
        logic [NB_DATA_BUS-1:0] r;
        for (int i = 0; i < N_LANES; i++) r[i*66 +: 66] = b;
        return r;
    endfunction

    function automatic logic [65:0] mk(input logic [23:0] m, input logic [7:0] b);
        return {2'b10, m, b, ~m, ~b};
    endfunction

    task automatic step(input logic v, input logic t, input logic [65:0] b);
        i_valid = v;
        i_tag = t;
        i_data = rep(b);
        @(posedge i_clock);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge i_clock);
        #1;
        tot++; if (o_data !== '0) begin bad++; $display("FAIL reset_data got=%h", o_data[65:0]); end
        tot++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        tot++; if (o_am_insert !== 1'b0) begin bad++; $display("FAIL reset_insert got=%b exp=0", o_am_insert); end
        tot++; if (o_rf_gap_error_counter !== '0) begin bad++; $display("FAIL reset_err got=%0d exp=0", o_rf_gap_error_counter); end
        tot++; if (o_rf_am_locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b exp=0", o_rf_am_locked); end
        i_reset = 1'b1;
        i_rf_enb = 1'b1;
    endtask

    task automatic test_periodic;
        step(1, 0, D01);
        tot++; if (o_am_insert !== 1'b0 || o_data !== rep(D01) || o_valid !== 1'b1 || o_rf_am_locked !== 1'b0) begin
            bad++; $display("FAIL pass_first ins=%b v=%b lock=%b lane0=%h", o_am_insert, o_valid, o_rf_am_locked, o_data[65:0]); end
        step(1, 1, TG);
        tot++; if (o_am_insert !== 1'b1 || o_data[65:0] !== mk(M_L0, 8'h08)) begin
            bad++; $display("FAIL first_marker_l0 ins=%b got=%h exp=%h", o_am_insert, o_data[65:0], mk(M_L0, 8'h08)); end
        tot++; if (o_data[19*66 +: 66] !== mk(M_L19, 8'h08)) begin
            bad++; $display("FAIL first_marker_l19 got=%h exp=%h", o_data[19*66 +: 66], mk(M_L19, 8'h08)); end
        tot++; if (o_rf_am_locked !== 1'b1) begin bad++; $display("FAIL lock_first got=%b exp=1", o_rf_am_locked); end
        for (int i = 0; i < 4; i++) begin
            step(1, 0, D01);
            tot++; if (o_am_insert !== 1'b0 || o_data !== rep(D01)) begin
                bad++; $display("FAIL periodic_pass%0d ins=%b lane0=%h", i, o_am_insert, o_data[65:0]); end
        end
        step(1, 1, TG);
        tot++; if (o_am_insert !== 1'b1 || o_data[65:0] !== mk(M_L0, 8'h10)) begin
            bad++; $display("FAIL second_marker ins=%b got=%h exp=%h", o_am_insert, o_data[65:0], mk(M_L0, 8'h10)); end
        for (int i = 0; i < 3; i++) step(1, 0, D2);
        step(1, 0, D01);
        step(1, 1, TG);
        tot++; if (o_am_insert !== 1'b1 || o_data[65:0] !== mk(M_L0, 8'h09)) begin
            bad++; $display("FAIL mixed_bip ins=%b got=%h exp=%h", o_am_insert, o_data[65:0], mk(M_L0, 8'h09)); end
        tot++; if (o_rf_gap_error_counter !== 16'd0) begin bad++; $display("FAIL periodic_err got=%0d exp=0", o_rf_gap_error_counter); end
    endtask

    task automatic test_early_tag;
        repeat (2) step(1, 0, D01);
        step(1, 1, TG);
        tot++; if (o_am_insert !== 1'b1 || o_data[65:0] !== mk(M_L0, 8'h10)) begin
            bad++; $display("FAIL early_marker ins=%b got=%h exp=%h", o_am_insert, o_data[65:0], mk(M_L0, 8'h10)); end
        tot++; if (o_rf_gap_error_counter !== 16'd1) begin bad++; $display("FAIL early_err got=%0d exp=1", o_rf_gap_error_counter); end
        repeat (4) step(1, 0, D01);
        step(1, 1, TG);
        tot++; if (o_am_insert !== 1'b1 || o_rf_gap_error_counter !== 16'd1) begin
            bad++; $display("FAIL early_respace ins=%b err=%0d exp ins=1 err=1", o_am_insert, o_rf_gap_error_counter); end
    endtask

    task automatic test_missing_tag;
        repeat (4) step(1, 0, D01);
        step(1, 0, D01);
        tot++; if (o_am_insert !== 1'b0 || o_data !== rep(D01)) begin
            bad++; $display("FAIL missing_pass ins=%b lane0=%h", o_am_insert, o_data[65:0]); end
        tot++; if (o_rf_gap_error_counter !== 16'd2 || o_rf_am_locked !== 1'b0) begin
            bad++; $display("FAIL missing_err err=%0d lock=%b exp err=2 lock=0", o_rf_gap_error_counter, o_rf_am_locked); end
        step(1, 1, TG);
        tot++; if (o_am_insert !== 1'b1 || o_rf_am_locked !== 1'b1 || o_data[65:0] !== mk(M_L0, 8'h18)) begin
            bad++; $display("FAIL relock ins=%b lock=%b got=%h exp=%h", o_am_insert, o_rf_am_locked, o_data[65:0], mk(M_L0, 8'h18)); end
    endtask

    task automatic test_valid_gaps;
        for (int i = 0; i < 4; i++) begin
            step(1, 0, D01);
            step(0, 1, D2);
            tot++; if (o_valid !== 1'b0 || o_am_insert !== 1'b0 || o_data !== rep(D01)) begin
                bad++; $display("FAIL gap_hold%0d v=%b ins=%b lane0=%h", i, o_valid, o_am_insert, o_data[65:0]); end
        end
        step(1, 1, TG);
        tot++; if (o_am_insert !== 1'b1 || o_valid !== 1'b1 || o_data[65:0] !== mk(M_L0, 8'h10)) begin
            bad++; $display("FAIL gap_marker ins=%b got=%h exp=%h", o_am_insert, o_data[65:0], mk(M_L0, 8'h10)); end
        tot++; if (o_rf_gap_error_counter !== 16'd2) begin bad++; $display("FAIL gap_err got=%0d exp=2", o_rf_gap_error_counter); end
    endtask

    task automatic test_period_zero;
        i_rf_am_period = 14'd0;
        for (int i = 0; i < 2; i++) begin
            step(1, 1, TG);
            tot++; if (o_am_insert !== 1'b1 || o_data[65:0] !== mk(M_L0, 8'h10) || o_rf_gap_error_counter !== 16'd2) begin
                bad++; $display("FAIL period0_%0d ins=%b err=%0d got=%h", i, o_am_insert, o_rf_gap_error_counter, o_data[65:0]); end
        end
        i_rf_am_period = 14'd4;
    endtask

    task automatic test_disable;
        step(1, 0, D01);
        i_rf_enb = 1'b0;
        step(1, 0, D01);
        tot++; if (o_rf_am_locked !== 1'b0 || o_data !== rep(D01) || o_rf_gap_error_counter !== 16'd2) begin
            bad++; $display("FAIL disable lock=%b err=%0d lane0=%h", o_rf_am_locked, o_rf_gap_error_counter, o_data[65:0]); end
        i_rf_enb = 1'b1;
        step(1, 0, D01);
        step(1, 1, TG);
        tot++; if (o_am_insert !== 1'b1 || o_rf_am_locked !== 1'b1 || o_data[65:0] !== mk(M_L0, 8'h08)) begin
            bad++; $display("FAIL reenable ins=%b lock=%b got=%h exp=%h", o_am_insert, o_rf_am_locked, o_data[65:0], mk(M_L0, 8'h08)); end
    endtask

    task automatic test_reset_mid;
        repeat (2) step(1, 0, D01);
        i_reset = 1'b0;
        @(posedge i_clock);
        #1;
        tot++; if (o_data !== '0 || o_valid !== 1'b0 || o_am_insert !== 1'b0 || o_rf_gap_error_counter !== '0 || o_rf_am_locked !== 1'b0) begin
            bad++; $display("FAIL midreset v=%b ins=%b err=%0d lock=%b lane0=%h", o_valid, o_am_insert, o_rf_gap_error_counter, o_rf_am_locked, o_data[65:0]); end
        i_reset = 1'b1;
        step(1, 0, D01);
        tot++; if (o_rf_am_locked !== 1'b0 || o_data !== rep(D01)) begin
            bad++; $display("FAIL postreset_pass lock=%b lane0=%h", o_rf_am_locked, o_data[65:0]); end
        step(1, 1, TG);
        tot++; if (o_am_insert !== 1'b1 || o_rf_am_locked !== 1'b1 || o_data[65:0] !== mk(M_L0, 8'h08)) begin
            bad++; $display("FAIL postreset_relock ins=%b lock=%b got=%h exp=%h", o_am_insert, o_rf_am_locked, o_data[65:0], mk(M_L0, 8'h08)); end
    endtask

    initial begin
        test_reset;
        test_periodic;
        test_early_tag;
        test_missing_tag;
        test_valid_gaps;
        test_period_zero;
        test_disable;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
